// File: rtl/qspi_xip_sequencer.sv
// Execute-in-place read sequencer: arbitrates fetch/load reads, fills a one-line buffer
// through the QSPI master's register port and serves later hits from that buffer.
module qspi_xip_sequencer #(
    parameter int unsigned LINE_WORDS = 8,
    parameter logic [7:0]  READ_CMD   = 8'hEB,
    parameter logic [16:0] CCR_CFG    = 17'h00000,
    parameter logic [5:0]  CLK_DIV    = 6'd2,
    parameter logic [15:0] TIMEOUT    = 16'd4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        ld_req_i,
    input  logic [31:0] ld_addr_i,
    output logic        ld_gnt_o,
    output logic        ld_rvalid_o,
    output logic [31:0] ld_rdata_o,
    output logic        ld_err_o,
    input  logic        inv_i,
    output logic        qspi_write_o,
    output logic [3:0]  qspi_be_o,
    output logic [5:0]  qspi_addr_o,
    output logic [31:0] qspi_wdata_o,
    input  logic [31:0] qspi_rdata_i,
    output logic        busy_o
);
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
    localparam int unsigned IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [31:0] OFF_MASK   = 32'(LINE_BYTES - 1);
    localparam logic [29:0] IDX_MASK   = 30'(LINE_WORDS - 1);
    localparam logic [3:0]  LAST_K     = 4'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADR  = 3'd1;
    localparam logic [2:0] S_WCCR  = 3'd2;
    localparam logic [2:0] S_POLL  = 3'd3;
    localparam logic [2:0] S_RDDR  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;
    localparam logic [2:0] S_ABORT = 3'd6;

    logic [2:0]  r_state;
    logic        r_valid;
    logic        r_stale;
    logic        r_fill;
    logic        r_sel_ld;
    logic        r_last_ld;
    logic        r_started;
    logic [31:0] r_tag;
    logic [31:0] r_addr;
    logic [15:0] r_tout;
    logic [3:0]  r_k;
    logic [31:0] r_buf [LINE_WORDS];

    logic             w_pick_ld;
    logic             w_any_req;
    logic             w_hit;
    logic [31:0]      w_req_addr;
    logic [IDX_W-1:0] w_word_sel;
    logic [31:0]      w_resp_data;
    logic             w_sta_busy;
    logic             w_sta_done;
    logic             w_resp;
    logic             w_abort;

    // Round-robin: load wins a tie unless it was the last port granted.
    assign w_any_req   = if_req_i | ld_req_i;
    assign w_pick_ld   = ld_req_i & (~if_req_i | ~r_last_ld);
    assign w_req_addr  = w_pick_ld ? ld_addr_i : if_addr_i;
    assign w_hit       = r_valid & ~inv_i & ((w_req_addr & ~OFF_MASK) == r_tag);
    assign w_word_sel  = IDX_W'(r_addr[31:2] & IDX_MASK);
    assign w_resp_data = r_buf[w_word_sel];
    assign w_sta_busy  = qspi_rdata_i[1];
    assign w_sta_done  = qspi_rdata_i[0] & ~qspi_rdata_i[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_stale   <= 1'b0;
            r_fill    <= 1'b0;
            r_sel_ld  <= 1'b0;
            r_last_ld <= 1'b0;
            r_started <= 1'b0;
            r_tag     <= '0;
            r_addr    <= '0;
            r_tout    <= '0;
            r_k       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel_ld  <= w_pick_ld;
                        r_last_ld <= w_pick_ld;
                        r_addr    <= w_req_addr;
                        if (w_hit) begin
                            r_fill  <= 1'b0;
                            r_state <= S_RESP;
                        end else begin
                            // The buffer is about to be overwritten, so it stops being valid now.
                            r_fill  <= 1'b1;
                            r_valid <= 1'b0;
                            r_stale <= 1'b0;
                            r_state <= S_WADR;
                        end
                    end else if (inv_i) begin
                        r_valid <= 1'b0;
                    end
                end
                S_WADR: r_state <= S_WCCR;
                S_WCCR: begin
                    r_tout    <= '0;
                    r_started <= 1'b0;
                    r_state   <= S_POLL;
                end
                S_POLL: begin
                    if (r_started && w_sta_done) begin
                        r_k     <= '0;
                        r_state <= S_RDDR;
                    end else if (r_tout == TIMEOUT - 16'd1) begin
                        r_state <= S_ABORT;
                    end else begin
                        r_tout <= r_tout + 16'd1;
                        if (w_sta_busy) r_started <= 1'b1;
                    end
                end
                S_RDDR: begin
                    if (r_k == LAST_K) r_state <= S_RESP;
                    else               r_k     <= r_k + 4'd1;
                end
                S_RESP: begin
                    if (r_fill) begin
                        r_tag   <= r_addr & ~OFF_MASK;
                        r_valid <= ~(r_stale | inv_i);
                    end else if (inv_i) begin
                        r_valid <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (inv_i && r_state inside {S_WADR, S_WCCR, S_POLL, S_RDDR}) r_stale <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == S_RDDR) r_buf[IDX_W'(r_k)] <= qspi_rdata_i;
    end

    always_comb begin
        qspi_write_o = 1'b0;
        qspi_be_o    = 4'h0;
        qspi_addr_o  = 6'h00;
        qspi_wdata_o = 32'h0;
        case (r_state)
            S_WADR: begin
                qspi_write_o = 1'b1;
                qspi_be_o    = 4'hF;
                qspi_addr_o  = 6'h04;
                qspi_wdata_o = r_addr & ~OFF_MASK;
            end
            S_WCCR: begin
                qspi_write_o = 1'b1;
                qspi_be_o    = 4'hF;
                qspi_wdata_o = {1'b0, CLK_DIV, CCR_CFG, READ_CMD};
            end
            S_POLL: begin
                qspi_be_o   = 4'h1;
                qspi_addr_o = 6'h28;
            end
            S_RDDR: begin
                qspi_be_o   = 4'hF;
                qspi_addr_o = 6'h08 + {r_k, 2'b00};
            end
            S_ABORT: begin
                qspi_write_o = 1'b1;
                qspi_be_o    = 4'hF;
                qspi_wdata_o = 32'h8000_0000;
            end
            default: ;
        endcase
    end

    assign w_resp  = (r_state == S_RESP);
    assign w_abort = (r_state == S_ABORT);

    assign if_gnt_o    = (r_state == S_IDLE) & if_req_i & ~w_pick_ld;
    assign ld_gnt_o    = (r_state == S_IDLE) & w_pick_ld;
    assign if_rvalid_o = (w_resp | w_abort) & ~r_sel_ld;
    assign ld_rvalid_o = (w_resp | w_abort) & r_sel_ld;
    assign if_err_o    = w_abort & ~r_sel_ld;
    assign ld_err_o    = w_abort & r_sel_ld;
    assign if_rdata_o  = (w_resp & ~r_sel_ld) ? w_resp_data : 32'h0;
    assign ld_rdata_o  = (w_resp & r_sel_ld) ? w_resp_data : 32'h0;
    assign busy_o      = (r_state != S_IDLE);

endmodule
